spi_slave_frame: RTL and testbench
==================================

Name: spi_slave_frame

Overview:
- Parametrised SPI slave frame interface. Next generation of the fixed 56/48-bit command interface.
- Adds configurable command and response widths, all four SPI modes (CPOL/CPHA) and frame-length checking.
- Sits between the external MCU SPI pins and the command decoder.
- Delivers each received command word with a one-cycle valid pulse, and shifts a response word back out during the same transaction.

Parameters:
- CMD_W, 56: command (MOSI) frame width in bits; >= 2.
- RSP_W, 48: response (MISO) word width in bits; 1 <= RSP_W <= CMD_W.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser; >= 2.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- nrst, input, 1: reset, synchronous, active-low.
- spi_clk, input, 1: SPI SCK, asynchronous.
- spi_ss, input, 1: SPI slave select, active-low, asynchronous.
- spi_mosi, input, 1: SPI data in, asynchronous.
- spi_miso, output, 1: SPI data out.
- cmd_read, output, CMD_W: last correctly sized command received, MSB first.
- cmd_write, input, RSP_W: response word, captured at frame start.
- valid, output, 1: one-cycle pulse; cmd_read was updated.
- frame_err, output, 1: one-cycle pulse; frame ended with a bit count other than CMD_W.
- busy, output, 1: high while a frame is in progress (synchronised SS low).

Behaviour:
- Reset (nrst low at a clk edge):
  - cmd_read = 0, valid = 0, frame_err = 0, busy = 0, spi_miso = 0.
  - Bit counter = 0. Shift registers = 0.
  - Synchroniser stages and last-SS register = 1, so no spurious SS edge is seen after reset; last-SCK register = CPOL.
  - Reset mid-frame discards the frame: no valid, no frame_err. The block waits for the next SS falling edge; a frame already in progress at reset release is ignored until SS goes high.
- Synchronisation: SCK, SS and MOSI each pass through SYNC_STAGES flops. Edges are detected against a registered copy of the synchronised signal.
- Edge naming:
  - Leading edge = rising if CPOL = 0, falling if CPOL = 1. Trailing edge is the opposite.
  - Sample edge = leading if CPHA = 0, else trailing. Shift edge is the other one.
- States:
  - IDLE (SS high): on synchronised SS falling edge -> ACTIVE. In that cycle: out_reg = {cmd_write, (CMD_W-RSP_W) zeros}, in_reg = 0, bit counter = 0.
  - ACTIVE (SS low):
    - Each sample edge shifts in_reg left with MOSI entering at the LSB. Bit counter increments, saturating at CMD_W+1.
    - Each shift edge shifts out_reg left, filling with 0.
    - For CPHA = 1, the first leading edge of the frame does not shift: it presents the MSB.
    - On SS rising edge -> DONE.
  - DONE (one cycle):
    - If count == CMD_W: cmd_read <= in_reg, valid = 1.
    - Otherwise: frame_err = 1 and cmd_read is unchanged.
    - Always -> IDLE.
- spi_miso = out_reg MSB while busy, else 0. For CPHA = 0 the MSB is valid before the first sample edge.
- Simultaneous events:
  - SCK edge in the same cycle as the SS rising edge: the SCK edge is ignored.
  - SCK edges while SS is high are ignored.
  - SS falling edge in the same cycle as DONE cannot occur; minimum SS high time is 2 clk.
- cmd_write is sampled only at the SS falling edge. Later changes do not affect the frame in progress.
- Latency:
  - valid pulses exactly SYNC_STAGES+2 clk after the SS pin rises.
  - busy rises SYNC_STAGES+1 clk after the SS pin falls.
- Extra bits beyond CMD_W: in_reg holds the last CMD_W bits; frame_err is still raised.
- SPI timing constraint: each SCK phase must last >= SYNC_STAGES+1 clk.

Test Plan:
- Mode 0, CMD_W = 56, RSP_W = 48, cmd_write = 48'hA5A5_1234_5678, MOSI = 56'hDE_ADBE_EF01_2345 -> cmd_read = 56'hDEADBEEF012345; valid high for exactly 1 clk; MISO stream = A5A512345678 followed by 8 zero bits.
- Modes 1, 2 and 3, same data -> identical cmd_read and MISO bit stream, sampled at the mode's sample edge.
- Short frame of 55 bits, then long frame of 57 bits -> frame_err pulses once per frame; valid stays 0; cmd_read keeps its prior value.
- Change cmd_write to 48'hFFFF_FFFF_FFFF mid-frame -> MISO continues the originally captured word.
- nrst low for 1 clk after 20 bits, then a full valid frame -> no pulse for the aborted frame; the next frame gives valid and correct data; outputs are 0 during reset.
- CMD_W = 8, RSP_W = 8, SYNC_STAGES = 3: frame 8'h3C with response 8'hC3 -> cmd_read = 8'h3C; MISO = C3; valid arrives 5 clk after the SS pin rises.

Source files
------------

// File: rtl/spi_slave_frame.sv
// SPI slave frame interface: synchronises the SPI pins into the clk domain,
// receives a CMD_W-bit command MSB first and shifts back a RSP_W-bit response
// in the same transaction. Supports all four CPOL/CPHA modes and flags frames
// whose bit count differs from CMD_W.
module spi_slave_frame #(
   parameter int unsigned CMD_W       = 56,
   parameter int unsigned RSP_W       = 48,
   parameter int unsigned CPOL        = 0,
   parameter int unsigned CPHA        = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             spi_clk,
   input  logic             spi_ss,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic [CMD_W-1:0] cmd_read,
   input  logic [RSP_W-1:0] cmd_write,
   output logic             valid,
   output logic             frame_err,
   output logic             busy
);

   localparam int unsigned CNT_W    = $clog2(CMD_W + 2);
   localparam logic        SCK_IDLE = (CPOL != 0);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] fill;
   logic                   sck_s;
   logic                   ss_s;
   logic                   mosi_s;
   logic                   last_sck;
   logic                   last_ss;
   logic                   armed;
   logic                   lead_seen;
   logic [CMD_W-1:0]       in_reg;
   logic [CMD_W-1:0]       out_reg;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   lead_edge;
   logic                   trail_edge;
   logic                   sample_edge;
   logic                   shift_edge;
   logic                   ss_fall;
   logic                   ss_rise;

   // Input synchronisers; fill tracks when the last stage holds real pin data.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         sck_sync  <= '1;
         ss_sync   <= '1;
         mosi_sync <= '1;
         fill      <= '0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Edge detection and mapping of SCK edges onto sample/shift roles.
   always_comb begin
      sck_rise    = ~last_sck & sck_s;
      sck_fall    = last_sck & ~sck_s;
      lead_edge   = (CPOL != 0) ? sck_fall : sck_rise;
      trail_edge  = (CPOL != 0) ? sck_rise : sck_fall;
      sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
      shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
      // A falling SS only counts once SS has been seen high after reset, so a
      // frame already running at reset release is ignored.
      ss_fall     = armed & last_ss & ~ss_s;
      ss_rise     = ~last_ss & ss_s;
   end

   // Frame FSM: capture at SS fall, shift during the frame, report at SS rise.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state     <= IDLE;
         last_sck  <= SCK_IDLE;
         last_ss   <= 1'b1;
         armed     <= 1'b0;
         lead_seen <= 1'b0;
         in_reg    <= '0;
         out_reg   <= '0;
         bit_cnt   <= '0;
         cmd_read  <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         last_sck  <= sck_s;
         last_ss   <= ss_s;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         if (fill[SYNC_STAGES-1] && ss_s) begin
            armed <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state     <= ACTIVE;
                  busy      <= 1'b1;
                  out_reg   <= CMD_W'(cmd_write) << (CMD_W - RSP_W);
                  in_reg    <= '0;
                  bit_cnt   <= '0;
                  lead_seen <= 1'b0;
               end
            end
            ACTIVE: begin
               if (ss_rise) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end else begin
                  if (sample_edge) begin
                     in_reg <= {in_reg[CMD_W-2:0], mosi_s};
                     if (bit_cnt != CNT_W'(CMD_W + 1)) begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
                  if (shift_edge) begin
                     // With CPHA=1 the first leading edge only presents the MSB.
                     if (CPHA != 0 && !lead_seen) begin
                        lead_seen <= 1'b1;
                     end else begin
                        out_reg <= {out_reg[CMD_W-2:0], 1'b0};
                     end
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               if (bit_cnt == CNT_W'(CMD_W)) begin
                  cmd_read <= in_reg;
                  valid    <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign spi_miso = busy & out_reg[CMD_W-1];

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame: four 56/48-bit instances (one per SPI
// mode) plus one 8/8-bit instance with three synchroniser stages.
module tb_spi_slave_frame;

   localparam int HP = 6;  // SCK half period in clk cycles

   logic        clk  = 1'b0;
   logic        nrst = 1'b0;
   logic [4:0]  sck  = 5'b01100;
   logic [4:0]  ss   = 5'b11111;
   logic [4:0]  mosi = 5'b00000;
   wire  [4:0]  miso;
   wire  [4:0]  valid_v;
   wire  [4:0]  ferr_v;
   wire  [4:0]  busy_v;
   wire  [55:0] cr [4];
   logic [47:0] cw [4] = '{default: '0};
   wire  [7:0]  cr8;
   logic [7:0]  cw8 = 8'h00;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int vcnt [5]    = '{default: 0};
   int ecnt [5]    = '{default: 0};
   int vcyc [5]    = '{default: 0};
   int bcyc [5]    = '{default: 0};
   logic [4:0]  bprev = 5'b00000;

   logic [63:0] last_miso;
   int          last_fall;
   int          last_rise;
   logic [3:0]  snap_flags;
   logic [55:0] snap_cr;

   always #5 clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_mode
      spi_slave_frame #(
         .CMD_W(56), .RSP_W(48), .CPOL(m / 2), .CPHA(m % 2), .SYNC_STAGES(2)
      ) u_dut (
         .clk(clk), .nrst(nrst), .spi_clk(sck[m]), .spi_ss(ss[m]),
         .spi_mosi(mosi[m]), .spi_miso(miso[m]), .cmd_read(cr[m]),
         .cmd_write(cw[m]), .valid(valid_v[m]), .frame_err(ferr_v[m]),
         .busy(busy_v[m])
      );
   end

   spi_slave_frame #(
      .CMD_W(8), .RSP_W(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(3)
   ) u_small (
      .clk(clk), .nrst(nrst), .spi_clk(sck[4]), .spi_ss(ss[4]),
      .spi_mosi(mosi[4]), .spi_miso(miso[4]), .cmd_read(cr8),
      .cmd_write(cw8), .valid(valid_v[4]), .frame_err(ferr_v[4]),
      .busy(busy_v[4])
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: counts valid/frame_err cycles, timestamps valid and busy rise.
   always @(negedge clk) begin
      for (int d = 0; d < 5; d++) begin
         if (valid_v[d]) begin
            vcnt[d] = vcnt[d] + 1;
            vcyc[d] = cyc;
         end
         if (ferr_v[d]) ecnt[d] = ecnt[d] + 1;
         if (busy_v[d] && !bprev[d]) bcyc[d] = cyc;
         bprev[d] = busy_v[d];
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Master-side frame driver; captures MISO at the mode's sample edge.
   task automatic run_frame(input int d, input int nbits, input logic [63:0] data,
                            input int chg_at, input int rst_at);
      logic pol;
      logic pha;
      pol = (d == 2 || d == 3);
      pha = (d == 1 || d == 3);
      last_miso = '0;
      @(negedge clk);
      ss[d] = 1'b0;
      last_fall = cyc;
      if (!pha) mosi[d] = data[nbits-1];
      wait_clk(HP);
      for (int i = 0; i < nbits; i++) begin
         if (!pha) last_miso = {last_miso[62:0], miso[d]};
         sck[d] = ~pol;
         if (pha) mosi[d] = data[nbits-1-i];
         wait_clk(HP);
         if (pha) last_miso = {last_miso[62:0], miso[d]};
         sck[d] = pol;
         if (!pha && i < nbits - 1) mosi[d] = data[nbits-2-i];
         if (i == chg_at && d < 4) cw[d] = 48'hFFFF_FFFF_FFFF;
         if (i == rst_at) begin
            @(negedge clk);
            nrst = 1'b0;
            @(negedge clk);
            snap_flags = {valid_v[d], ferr_v[d], busy_v[d], miso[d]};
            if (d < 4) snap_cr = cr[d];
            else       snap_cr = {48'h0, cr8};
            nrst = 1'b1;
         end
         wait_clk(HP);
      end
      ss[d] = 1'b1;
      last_rise = cyc;
      wait_clk(12);
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      wait_clk(3);
      for (int d = 0; d < 5; d++) begin
         vectors++;
         if ({valid_v[d], ferr_v[d], busy_v[d], miso[d]} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags d=%0d got %b want 0000", d,
                     {valid_v[d], ferr_v[d], busy_v[d], miso[d]});
         end
      end
      for (int d = 0; d < 4; d++) begin
         vectors++;
         if (cr[d] !== 56'h0) begin
            miscompares++;
            $display("FAIL reset_cmd_read d=%0d got %h want 0", d, cr[d]);
         end
      end
      vectors++;
      if (cr8 !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_cmd_read_small got %h want 00", cr8);
      end
      nrst = 1'b1;
      wait_clk(10);
   endtask

   task automatic test_mode(input int d);
      int v0, e0;
      v0 = vcnt[d];
      e0 = ecnt[d];
      cw[d] = 48'hA5A5_1234_5678;
      run_frame(d, 56, 64'h00DE_ADBE_EF01_2345, -1, -1);
      vectors++;
      if (cr[d] !== 56'hDE_ADBE_EF01_2345) begin
         miscompares++;
         $display("FAIL mode%0d_cmd_read got %h want deadbeef012345", d, cr[d]);
      end
      vectors++;
      if (last_miso !== 64'h00A5_A512_3456_7800) begin
         miscompares++;
         $display("FAIL mode%0d_miso got %h want 00a5a51234567800", d, last_miso);
      end
      vectors++;
      if (vcnt[d] - v0 !== 1) begin
         miscompares++;
         $display("FAIL mode%0d_valid_cycles got %0d want 1", d, vcnt[d] - v0);
      end
      vectors++;
      if (ecnt[d] - e0 !== 0) begin
         miscompares++;
         $display("FAIL mode%0d_frame_err got %0d want 0", d, ecnt[d] - e0);
      end
      vectors++;
      if (vcyc[d] - last_rise !== 4) begin
         miscompares++;
         $display("FAIL mode%0d_valid_latency got %0d want 4", d, vcyc[d] - last_rise);
      end
      vectors++;
      if (bcyc[d] - last_fall !== 3) begin
         miscompares++;
         $display("FAIL mode%0d_busy_latency got %0d want 3", d, bcyc[d] - last_fall);
      end
   endtask

   task automatic test_frame_err();
      int v0, e0;
      v0 = vcnt[0];
      e0 = ecnt[0];
      run_frame(0, 55, 64'h0055_AAAA_5555_AAAA, -1, -1);
      vectors++;
      if (ecnt[0] - e0 !== 1) begin
         miscompares++;
         $display("FAIL short_frame_err got %0d want 1", ecnt[0] - e0);
      end
      vectors++;
      if (cr[0] !== 56'hDE_ADBE_EF01_2345) begin
         miscompares++;
         $display("FAIL short_cmd_read got %h want deadbeef012345", cr[0]);
      end
      run_frame(0, 57, 64'h01FF_0000_FFFF_0000, -1, -1);
      vectors++;
      if (ecnt[0] - e0 !== 2) begin
         miscompares++;
         $display("FAIL long_frame_err got %0d want 2", ecnt[0] - e0);
      end
      vectors++;
      if (vcnt[0] - v0 !== 0) begin
         miscompares++;
         $display("FAIL bad_frames_valid got %0d want 0", vcnt[0] - v0);
      end
      vectors++;
      if (cr[0] !== 56'hDE_ADBE_EF01_2345) begin
         miscompares++;
         $display("FAIL long_cmd_read got %h want deadbeef012345", cr[0]);
      end
   endtask

   task automatic test_cmd_write_change();
      int v0;
      v0 = vcnt[0];
      cw[0] = 48'hA5A5_1234_5678;
      run_frame(0, 56, 64'h0011_2233_4455_6677, 10, -1);
      vectors++;
      if (last_miso !== 64'h00A5_A512_3456_7800) begin
         miscompares++;
         $display("FAIL cw_change_miso got %h want 00a5a51234567800", last_miso);
      end
      vectors++;
      if (cr[0] !== 56'h11_2233_4455_6677) begin
         miscompares++;
         $display("FAIL cw_change_cmd_read got %h want 11223344556677", cr[0]);
      end
      vectors++;
      if (vcnt[0] - v0 !== 1) begin
         miscompares++;
         $display("FAIL cw_change_valid got %0d want 1", vcnt[0] - v0);
      end
   endtask

   task automatic test_reset_midframe();
      int v0, e0;
      v0 = vcnt[0];
      e0 = ecnt[0];
      cw[0] = 48'hA5A5_1234_5678;
      run_frame(0, 56, 64'h0011_2233_4455_6677, -1, 19);
      vectors++;
      if (snap_flags !== 4'b0000) begin
         miscompares++;
         $display("FAIL midreset_flags got %b want 0000", snap_flags);
      end
      vectors++;
      if (snap_cr !== 56'h0) begin
         miscompares++;
         $display("FAIL midreset_cmd_read got %h want 0", snap_cr);
      end
      vectors++;
      if ((vcnt[0] - v0 !== 0) || (ecnt[0] - e0 !== 0)) begin
         miscompares++;
         $display("FAIL aborted_frame_pulses got v=%0d e=%0d want v=0 e=0",
                  vcnt[0] - v0, ecnt[0] - e0);
      end
      run_frame(0, 56, 64'h00C0_FFEE_1234_5678, -1, -1);
      vectors++;
      if (cr[0] !== 56'hC0_FFEE_1234_5678) begin
         miscompares++;
         $display("FAIL post_reset_cmd_read got %h want c0ffee12345678", cr[0]);
      end
      vectors++;
      if (vcnt[0] - v0 !== 1) begin
         miscompares++;
         $display("FAIL post_reset_valid got %0d want 1", vcnt[0] - v0);
      end
      vectors++;
      if (last_miso !== 64'h00A5_A512_3456_7800) begin
         miscompares++;
         $display("FAIL post_reset_miso got %h want 00a5a51234567800", last_miso);
      end
   endtask

   task automatic test_small();
      int v0;
      v0 = vcnt[4];
      cw8 = 8'hC3;
      run_frame(4, 8, 64'h3C, -1, -1);
      vectors++;
      if (cr8 !== 8'h3C) begin
         miscompares++;
         $display("FAIL small_cmd_read got %h want 3c", cr8);
      end
      vectors++;
      if (last_miso !== 64'hC3) begin
         miscompares++;
         $display("FAIL small_miso got %h want c3", last_miso);
      end
      vectors++;
      if (vcnt[4] - v0 !== 1) begin
         miscompares++;
         $display("FAIL small_valid got %0d want 1", vcnt[4] - v0);
      end
      vectors++;
      if (vcyc[4] - last_rise !== 5) begin
         miscompares++;
         $display("FAIL small_valid_latency got %0d want 5", vcyc[4] - last_rise);
      end
      vectors++;
      if (bcyc[4] - last_fall !== 4) begin
         miscompares++;
         $display("FAIL small_busy_latency got %0d want 4", bcyc[4] - last_fall);
      end
   endtask

   initial begin
      test_reset();
      for (int d = 0; d < 4; d++) test_mode(d);
      test_frame_err();
      test_cmd_write_change();
      test_reset_midframe();
      test_small();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
